regfile_sb: RTL
===============

Name: regfile_sb

Overview:
- Parametrised successor to the CPU's 32x32 register file.
- Provides two asynchronous read ports and one synchronous write port.
- Adds a multi-cycle post-reset clear sequencer, optional write-to-read bypass, and a per-register pending scoreboard used by issue logic for RAW hazard detection.
- Sits between decode/issue (reads, claims) and writeback (writes) in the pipelined core.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never pending; when 0 register 0 is an ordinary register.

Ports:
- clock  in  1  single rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  read port 1 data, combinational.
- rd_data2  out  DATA_W  read port 2 data, combinational.
- rd_pend1  out  1  pending bit of rd_addr1, combinational.
- rd_pend2  out  1  pending bit of rd_addr2, combinational.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- claim_en  in  1  mark claim_addr pending (instruction issued with this destination).
- claim_addr  in  ADDR_W  destination register being claimed.
- ready  out  1  high when the clear sequence is finished and the file is usable.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Storage: DEPTH x DATA_W array, not reset directly. It is cleared by the sequencer.
- Pending vector: DEPTH flops, all cleared on the reset cycle.
- FSM states: CLEAR and READY.
  - reset=1 at a rising edge: state<=CLEAR, clr_ptr<=0, ready<=0.
  - CLEAR: each cycle writes mem[clr_ptr]<=0 and increments clr_ptr. When clr_ptr==DEPTH-1, the write occurs and state<=READY.
  - The clear takes exactly DEPTH cycles after reset deasserts; ready rises on the edge after the final clear write.
  - READY: remains until the next reset. There is no other exit.
  - reset asserted mid-CLEAR restarts the sequence from clr_ptr=0.
- While ready=0:
  - wr_en and claim_en are ignored.
  - rd_data1/2 = 0 and rd_pend1/2 = 0.
- Write (ready=1): on a rising edge with wr_en=1, mem[wr_addr]<=wr_data and pend[wr_addr]<=0.
  - With ZERO_REG=1, wr_addr==0 is ignored entirely.
- Read:
  - rd_dataN = mem[rd_addrN] combinationally.
  - With ZERO_REG=1, rd_addrN==0 returns 0 regardless of array contents.
  - With ZERO_REG=1, rd_pendN is 0 for address 0.
- Claim (ready=1): on a rising edge with claim_en=1, pend[claim_addr]<=1.
  - With ZERO_REG=1, claim_addr==0 is ignored.
- Simultaneous claim and write to the same address in one cycle:
  - data is written;
  - pending ends at 1 (the claim represents a newer producer and wins).
- Simultaneous claim and write to different addresses: both take effect independently.
- Latency:
  - write-to-read without bypass: 1 cycle (visible after the edge);
  - claim-to-pending: 1 cycle;
  - write-to-pending-clear: 1 cycle.
- rd_addr1==rd_addr2 is legal; both ports return identical values.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - While ready=1, wr_en=1 and wr_addr==rd_addrN (and not register 0 when ZERO_REG=1), rd_dataN = wr_data combinationally in the same cycle.
  - rd_pendN is also forced 0 in that case, unless claim_en=1 with claim_addr==rd_addrN in the same cycle, in which case rd_pendN reflects the stored bit.
  - Gives 0-cycle write-to-read.
- Not defined: reads always return stored array contents and the stored pending bit; the same-cycle write is visible the following cycle.

Test Plan:
- Assert reset 1 cycle, then release:
  - ready=0 for exactly 32 cycles (DEPTH=32), then 1;
  - reading every address returns 0x00000000 with pend=0.
- ready=1; write reg21=17 and reg22=29 on consecutive cycles:
  - next cycle rd_addr1=21, rd_addr2=22 gives rd_data1=0x11, rd_data2=0x1D;
  - write reg0=0xDEADBEEF, then rd_addr1=0 gives 0 (ZERO_REG=1).
- Claim reg5 at cycle N: rd_pend1 (rd_addr1=5) goes to 1 at N+1. Write reg5=0xA5A5A5A5 at N+3: pend=0 and data=0xA5A5A5A5 at N+4. Claim and write reg5 together at N+5: pend=1, data updated at N+6.
- Reset pulsed at clear cycle 10: ready stays 0 for another full 32 cycles; a wr_en=1 to reg3 during clear has no effect, and reg3 reads 0 after ready.
- With REGFILE_BYPASS_EN, wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr2=7: rd_data2=0x12345678 in the same cycle. Without the macro, it reads the old value (0) that cycle and 0x12345678 the next.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with post-reset clear, RAW pending scoreboard, optional REGFILE_BYPASS_EN write-to-read bypass
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_pend1,
  output logic              rd_pend2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic              ready
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR = ZERO_REG != 0;
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;
  logic [0:0] state;
  logic [ADDR_W-1:0] clr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic we, ce, z1, z2, byp1, byp2;
  assign ready = state == READY;
  assign we = ready && wr_en && !(ZR && wr_addr == '0);
  assign ce = ready && claim_en && !(ZR && claim_addr == '0);
  assign z1 = !ready || (ZR && rd_addr1 == '0);
  assign z2 = !ready || (ZR && rd_addr2 == '0);
`ifdef REGFILE_BYPASS_EN
  assign byp1 = we && wr_addr == rd_addr1;
  assign byp2 = we && wr_addr == rd_addr2;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      state   <= clr_ptr == ADDR_W'(DEPTH - 1) ? READY : CLEAR;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset && state == CLEAR) mem[clr_ptr] <= '0;
    else if (!reset && we) mem[wr_addr] <= wr_data;
  end
  // claim is applied after the write so a same-address claim leaves the bit set
  always_ff @(posedge clock) begin
    if (reset) pend <= '0;
    else begin
      if (we) pend[wr_addr] <= 1'b0;
      if (ce) pend[claim_addr] <= 1'b1;
    end
  end
  always_comb begin
    rd_data1 = z1 ? '0 : byp1 ? wr_data : mem[rd_addr1];
    rd_data2 = z2 ? '0 : byp2 ? wr_data : mem[rd_addr2];
    rd_pend1 = z1 ? 1'b0 : (byp1 && !(ce && claim_addr == rd_addr1)) ? 1'b0 : pend[rd_addr1];
    rd_pend2 = z2 ? 1'b0 : (byp2 && !(ce && claim_addr == rd_addr2)) ? 1'b0 : pend[rd_addr2];
  end
endmodule
